// File: rtl/coin_credit_unit.sv
// coin_credit_unit: debounced coin intake, saturating credit count and game launch/refund sequencing
module coin_credit_unit #(
    parameter int PRICE       = 2,
    parameter int MAX_CREDIT  = 9,
    parameter int DEB_CYCLES  = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Coin_raw,
    input  logic       Start_btn,
    input  logic       Refund_btn,
    input  logic       Game_busy,
    output logic       Coin,
    output logic [3:0] Credits,
    output logic       Coin_reject,
    output logic       Refund_pulse,
    output logic       Fault
);
    localparam int DW = $clog2(DEB_CYCLES);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(ACK_TIMEOUT - 1);
    localparam logic [4:0]    PRICE5   = 5'(PRICE);
    localparam logic [4:0]    MAX5     = 5'(MAX_CREDIT);
    localparam logic [3:0]    MAX4     = 4'(MAX_CREDIT);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_ACK, PLAY, REFUND} state_t;

    state_t          r_state, w_next;
    logic            r_s1, r_s2, r_disarm;
    logic [DW-1:0]   r_deb_cnt;
    logic [TW-1:0]   r_to_cnt;
    logic [3:0]      r_credits;
    logic            r_coin, r_reject, r_refund, r_fault;
    logic            w_accept, w_start, w_launch, w_rf, w_timeout, w_take;
    logic [4:0]      w_dec, w_sum;
    logic [3:0]      w_cred_next;

    assign w_accept = !r_disarm && r_s2 && (r_deb_cnt == DEB_LAST);
    assign w_start  = Start_btn && ({1'b0, r_credits} >= PRICE5) && !Game_busy;

    // Synchronize the coin switch; count a stable high run to accept, then a stable low run to re-arm
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_disarm  <= 1'b0;
            r_deb_cnt <= '0;
        end else begin
            r_s1 <= Coin_raw;
            r_s2 <= r_s1;
            if (r_disarm) begin
                if (r_s2) r_deb_cnt <= '0;
                else if (r_deb_cnt == DEB_LAST) begin
                    r_deb_cnt <= '0;
                    r_disarm  <= 1'b0;
                end else r_deb_cnt <= r_deb_cnt + 1'b1;
            end else if (!r_s2) r_deb_cnt <= '0;
            else if (w_accept) begin
                r_deb_cnt <= '0;
                r_disarm  <= 1'b1;
            end else r_deb_cnt <= r_deb_cnt + 1'b1;
        end
    end

    // Next-state decode plus the single net credit update (decrements first, then coin, then restore)
    always_comb begin
        w_next    = r_state;
        w_launch  = 1'b0;
        w_rf      = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next   = LAUNCH;
                    w_launch = 1'b1;
                end else if (Refund_btn && r_credits != 4'd0) begin
                    w_next = REFUND;
                    w_rf   = 1'b1;
                end
            end
            LAUNCH:   w_next = WAIT_ACK;
            WAIT_ACK: begin
                if (Game_busy) w_next = PLAY;
                else if (r_to_cnt == TO_LAST) begin
                    w_next    = IDLE;
                    w_timeout = 1'b1;
                end
            end
            PLAY:     w_next = Game_busy ? PLAY : IDLE;
            REFUND: begin
                if (!r_refund) w_rf = 1'b1;
                else if (r_credits == 4'd0 && !w_accept) w_next = IDLE;
            end
            default:  w_next = IDLE;
        endcase
        w_dec       = {1'b0, r_credits} - (w_launch ? PRICE5 : 5'd0) - {4'd0, w_rf};
        w_take      = w_accept && (w_dec < MAX5);
        w_sum       = w_dec + {4'd0, w_take} + (w_timeout ? PRICE5 : 5'd0);
        w_cred_next = (w_sum > MAX5) ? MAX4 : w_sum[3:0];
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (Reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    // Registered credit count, ack timer and one-cycle output pulses
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_to_cnt  <= '0;
            r_credits <= 4'd0;
            r_coin    <= 1'b0;
            r_reject  <= 1'b0;
            r_refund  <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_to_cnt  <= (r_state == WAIT_ACK) ? r_to_cnt + 1'b1 : '0;
            r_credits <= w_cred_next;
            r_coin    <= w_launch;
            r_reject  <= w_accept && !w_take;
            r_refund  <= w_rf;
            r_fault   <= w_timeout;
        end
    end

    assign Coin         = r_coin;
    assign Credits      = r_credits;
    assign Coin_reject  = r_reject;
    assign Refund_pulse = r_refund;
    assign Fault        = r_fault;
endmodule

// File: tb/tb_coin_credit_unit.sv
// tb_coin_credit_unit: directed checks of debounce, launch, timeout, saturation, refund and reset
module tb_coin_credit_unit;
    logic       clk = 1'b0, Reset = 1'b1, Coin_raw = 1'b0, Start_btn = 1'b0, Refund_btn = 1'b0, Game_busy = 1'b0;
    logic       Coin, Coin_reject, Refund_pulse, Fault;
    logic [3:0] Credits;
    int n_checks = 0, n_errors = 0;
    int n_coin = 0, n_rej = 0, n_rf = 0, n_fault = 0, n_overlap = 0;

    coin_credit_unit dut (
        .clk(clk), .Reset(Reset), .Coin_raw(Coin_raw), .Start_btn(Start_btn),
        .Refund_btn(Refund_btn), .Game_busy(Game_busy), .Coin(Coin), .Credits(Credits),
        .Coin_reject(Coin_reject), .Refund_pulse(Refund_pulse), .Fault(Fault)
    );

    always #5 clk = ~clk;

    // Pulse tallies sampled mid-cycle
    always @(negedge clk) begin
        n_coin    += int'(Coin);
        n_rej     += int'(Coin_reject);
        n_rf      += int'(Refund_pulse);
        n_fault   += int'(Fault);
        n_overlap += int'(Coin && Refund_pulse);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin();
        Coin_raw = 1'b1;
        repeat (10) tick();
        Coin_raw = 1'b0;
        repeat (10) tick();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    int base, k;
    int exp_pulse [6] = '{1, 0, 1, 0, 1, 0};
    int exp_cred  [6] = '{2, 2, 1, 1, 0, 0};

    initial begin
        repeat (3) tick();
        check("rst_coin", int'(Coin), 0);
        check("rst_credits", int'(Credits), 0);
        check("rst_reject", int'(Coin_reject), 0);
        check("rst_refund", int'(Refund_pulse), 0);
        check("rst_fault", int'(Fault), 0);
        check("rst_state", int'(dut.r_state), 0);
        Reset = 1'b0;
        tick();

        for (int g = 1; g <= 3; g++) begin
            Coin_raw = 1'b1;
            repeat (g) tick();
            Coin_raw = 1'b0;
            repeat (6) tick();
        end
        check("glitch_credits", int'(Credits), 0);
        Coin_raw = 1'b1;
        repeat (5) tick();
        check("deb_cycle5", int'(Credits), 0);
        tick();
        check("deb_cycle6", int'(Credits), 1);
        repeat (4) tick();
        Coin_raw = 1'b0;
        repeat (10) tick();
        check("deb_once", int'(Credits), 1);

        put_coin();
        check("launch_pre", int'(Credits), 2);
        base = n_coin;
        Start_btn = 1'b1;
        tick();
        Start_btn = 1'b0;
        check("launch_coin", int'(Coin), 1);
        check("launch_credits", int'(Credits), 0);
        tick();
        check("launch_coin_drop", int'(Coin), 0);
        tick();
        Game_busy = 1'b1;
        repeat (20) tick();
        Game_busy = 1'b0;
        repeat (2) tick();
        check("launch_pulses", n_coin - base, 1);
        check("launch_idle", int'(dut.r_state), 0);
        Start_btn = 1'b1;
        repeat (3) tick();
        Start_btn = 1'b0;
        tick();
        check("nocredit_start", n_coin - base, 1);

        repeat (3) put_coin();
        base = n_fault;
        Start_btn = 1'b1;
        tick();
        Start_btn = 1'b0;
        check("to_coin", int'(Coin), 1);
        check("to_credits", int'(Credits), 1);
        k = 0;
        while (!Fault && k < 40) begin
            tick();
            k++;
        end
        check("to_cycles", k, 17);
        check("to_restore", int'(Credits), 3);
        tick();
        check("to_fault_once", n_fault - base, 1);

        do_reset();
        base = n_rej;
        repeat (9) put_coin();
        check("sat_no_rej9", n_rej - base, 0);
        put_coin();
        check("sat_credits", int'(Credits), 9);
        check("sat_reject", n_rej - base, 1);

        base = n_rej;
        Coin_raw = 1'b1;
        repeat (5) tick();
        Start_btn = 1'b1;
        tick();
        Start_btn = 1'b0;
        check("sim_coin", int'(Coin), 1);
        check("sim_credits", int'(Credits), 8);
        repeat (4) tick();
        Coin_raw = 1'b0;
        Game_busy = 1'b1;
        repeat (2) tick();
        check("sim_no_reject", n_rej - base, 0);
        check("sim_play", int'(dut.r_state), 3);
        Reset = 1'b1;
        tick();
        check("mid_rst_coin", int'(Coin), 0);
        check("mid_rst_credits", int'(Credits), 0);
        check("mid_rst_pulses", int'(Coin_reject) + int'(Refund_pulse) + int'(Fault), 0);
        check("mid_rst_state", int'(dut.r_state), 0);
        Reset = 1'b0;
        Game_busy = 1'b0;
        repeat (10) tick();

        repeat (3) put_coin();
        base = n_rf;
        Refund_btn = 1'b1;
        tick();
        Refund_btn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            check($sformatf("rf_pulse%0d", i), int'(Refund_pulse), exp_pulse[i]);
            check($sformatf("rf_cred%0d", i), int'(Credits), exp_cred[i]);
        end
        check("rf_idle", int'(dut.r_state), 0);
        check("rf_count", n_rf - base, 3);

        repeat (3) put_coin();
        base = n_rf;
        Coin_raw = 1'b1;
        tick();
        Refund_btn = 1'b1;
        tick();
        Refund_btn = 1'b0;
        repeat (8) tick();
        Coin_raw = 1'b0;
        repeat (15) tick();
        check("rfc_count", n_rf - base, 4);
        check("rfc_credits", int'(Credits), 0);
        check("rfc_idle", int'(dut.r_state), 0);
        check("no_overlap", n_overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
